// File: rtl/eurorack_pkg.sv
// Shared voltage-scale helpers and CV thresholds for the eurorack cores.
// Sample values are fixed point: a sample equals mV shifted left by the fractional bit count.
package eurorack_pkg;

  localparam int SCHMITT_HI = 2000;
  localparam int SCHMITT_LO = 500;
  localparam int GATE_HI    = 5000;

  function automatic int FROM_MV(input int mv, input int fp_offset);
    return mv <<< fp_offset;
  endfunction

endpackage

// File: rtl/clock_divider_if.sv
// Sample bus of the clock divider: one valid strobe, four CV inputs, four trigger outputs.
interface clock_divider_if #(
  parameter int W = 16
) ();

  logic                sample_valid;
  logic signed [W-1:0] sample_in0;
  logic signed [W-1:0] sample_in1;
  logic signed [W-1:0] sample_in2;
  logic signed [W-1:0] sample_in3;
  logic signed [W-1:0] sample_out0;
  logic signed [W-1:0] sample_out1;
  logic signed [W-1:0] sample_out2;
  logic signed [W-1:0] sample_out3;

  modport master (
    output sample_valid, sample_in0, sample_in1, sample_in2, sample_in3,
    input  sample_out0, sample_out1, sample_out2, sample_out3
  );

  modport slave (
    input  sample_valid, sample_in0, sample_in1, sample_in2, sample_in3,
    output sample_out0, sample_out1, sample_out2, sample_out3
  );

endinterface

// File: rtl/schmitt_edge.sv
// Hysteresis comparator on a CV sample stream with a same-strobe rising-edge flag.
module schmitt_edge
  import eurorack_pkg::*;
#(
  parameter int W         = 16,
  parameter int FP_OFFSET = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic signed [W-1:0] sample,
  output logic                state,
  output logic                rise
);

  localparam logic signed [W-1:0] TH_HI = W'(FROM_MV(SCHMITT_HI, FP_OFFSET));
  localparam logic signed [W-1:0] TH_LO = W'(FROM_MV(SCHMITT_LO, FP_OFFSET));

  logic r_state;
  logic w_next;

  always_comb begin
    w_next = r_state;
    if (sample > TH_HI)
      w_next = 1'b1;
    else if (sample < TH_LO)
      w_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= 1'b0;
    else if (sample_valid)
      r_state <= w_next;
  end

  assign state = r_state;
  // Combinational so the channel counters react on the same strobe that crosses the threshold.
  assign rise  = sample_valid & ~r_state & w_next;

endmodule

// File: rtl/clock_divider.sv
// Four-channel clock divider: in0 clocks, in1 resets, each channel emits a fixed-width trigger.
module clock_divider
  import eurorack_pkg::*;
#(
  parameter int W            = 16,
  parameter int FP_OFFSET    = 2,
  parameter int DIV1         = 2,
  parameter int DIV2         = 3,
  parameter int DIV3         = 4,
  parameter int TRIG_SAMPLES = 48
) (
  input  logic            clk,
  input  logic            rst_n,
  clock_divider_if.slave  io
);

  localparam logic signed [W-1:0] OUT_HI = W'(FROM_MV(GATE_HI, FP_OFFSET));
  localparam logic [15:0]         TRIG   = 16'(TRIG_SAMPLES);

  logic w_clk_state;
  logic w_clk_rise;
  logic w_rst_state;
  logic w_rst_rise;
  logic w_unused;

  logic signed [W-1:0] w_out [4];

  schmitt_edge #(.W(W), .FP_OFFSET(FP_OFFSET)) u_clk_det (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (io.sample_valid),
    .sample       (io.sample_in0),
    .state        (w_clk_state),
    .rise         (w_clk_rise)
  );

  schmitt_edge #(.W(W), .FP_OFFSET(FP_OFFSET)) u_rst_det (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (io.sample_valid),
    .sample       (io.sample_in1),
    .state        (w_rst_state),
    .rise         (w_rst_rise)
  );

  for (genvar k = 0; k < 4; k++) begin : g_ch
    localparam int RATIO = (k == 0) ? 1 : (k == 1) ? DIV1 : (k == 2) ? DIV2 : DIV3;
    localparam logic [7:0] LAST = 8'(RATIO - 1);

    logic [7:0]          r_phase;
    logic [15:0]         r_width;
    logic signed [W-1:0] r_out;
    logic                w_fire;
    logic [7:0]          w_phase_nxt;
    logic [15:0]         w_width_nxt;

    always_comb begin
      w_fire      = 1'b0;
      w_phase_nxt = r_phase;
      // Coincident reset+clock behaves as reset-to-zero followed by the clock edge.
      if (w_clk_rise && w_rst_rise) begin
        w_fire      = 1'b1;
        w_phase_nxt = (RATIO == 1) ? 8'd0 : 8'd1;
      end else if (w_clk_rise) begin
        w_fire      = (r_phase == 8'd0);
        w_phase_nxt = (r_phase == LAST) ? 8'd0 : r_phase + 8'd1;
      end else if (w_rst_rise) begin
        w_phase_nxt = 8'd0;
      end

      if (w_fire)
        w_width_nxt = TRIG;
      else if (r_width != 16'd0)
        w_width_nxt = r_width - 16'd1;
      else
        w_width_nxt = r_width;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_phase <= 8'd0;
        r_width <= 16'd0;
        r_out   <= '0;
      end else if (io.sample_valid) begin
        r_phase <= w_phase_nxt;
        r_width <= w_width_nxt;
        r_out   <= (w_width_nxt != 16'd0) ? OUT_HI : '0;
      end
    end

    assign w_out[k] = r_out;
  end

  assign io.sample_out0 = w_out[0];
  assign io.sample_out1 = w_out[1];
  assign io.sample_out2 = w_out[2];
  assign io.sample_out3 = w_out[3];

  assign w_unused = ^{w_clk_state, w_rst_state, io.sample_in2, io.sample_in3};

endmodule

// File: doc/clock_divider.md
CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter W, 16, sample width in bits.
REQ-002 Parameter FP_OFFSET, 2, count of fractional bits; a sample value equals mV << FP_OFFSET.
REQ-003 Parameter DIV1 / DIV2 / DIV3, 2 / 3 / 4, division ratio of outputs 1-3; each SHALL be in the range 1-255.
REQ-004 Parameter TRIG_SAMPLES, 48, output trigger width in sample strobes; SHALL be in the range 1-65535.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 sample_valid  in  1  one-cycle strobe marking a new sample on the inputs.
REQ-008 sample_in0  in  W signed  clock CV.
REQ-009 sample_in1  in  W signed  reset CV.
REQ-010 sample_in2, sample_in3  in  W signed  unused; SHALL be ignored.
REQ-011 sample_out0..sample_out3  out  W signed  trigger outputs, registered.

Function
REQ-012 Samples are evaluated only in cycles where sample_valid=1; in all other cycles all state SHALL hold.
REQ-013 Each CV input SHALL pass through a Schmitt detector: high when the sample > FROM_MV(2000), low when the sample < FROM_MV(500), otherwise hold the previous state.
REQ-014 A clock edge is a low-to-high transition of the in0 detector; a reset edge is a low-to-high transition of the in1 detector.
REQ-015 Channel k (0-3) SHALL have a ratio R0=1 and Rk=DIVk, a phase counter p_k of 8 bits, and a width counter w_k of 16 bits.
REQ-016 On a clock edge without a reset edge: if p_k==0, channel k fires; p_k <= (p_k==Rk-1) ? 0 : p_k+1.
REQ-017 On a reset edge without a clock edge: all p_k <= 0; no channel fires.
REQ-018 On a reset edge and a clock edge in the same strobe: the counters are treated as 0, all channels fire, and p_k <= (Rk==1) ? 0 : 1.
REQ-019 Fire: w_k <= TRIG_SAMPLES, which retriggers and reloads even if w_k != 0. Otherwise, on each strobe, w_k decrements when it is nonzero and saturates at 0.
REQ-020 On each strobe, sample_out_k <= (next w_k != 0) ? FROM_MV(5000) : 0, so the output is high for exactly TRIG_SAMPLES strobes starting at the firing strobe.
REQ-021 Latency: an output SHALL change in the cycle after the clk edge that samples the triggering sample_valid.
REQ-022 With DIVk=1, channel k SHALL fire on every clock edge.

Reset
REQ-023 rst_n=0 SHALL force, asynchronously: both detectors low, all p_k=0, all w_k=0, all outputs=0.
REQ-024 The first clock edge after reset SHALL fire all four channels.
REQ-025 Reset asserted during an active trigger SHALL clear the trigger immediately; no trigger resumes after release.

Structure
REQ-026 Package eurorack_pkg SHALL hold the FROM_MV conversion function and the SCHMITT_HI, SCHMITT_LO and GATE_HI constants, shared by all cores.
REQ-027 Sub-module schmitt_edge (inputs clk, rst_n, sample_valid, sample; outputs state, rise) SHALL be instantiated twice, once for in0 and once for in1.
REQ-028 The channel logic SHALL be a generate loop over k=0..3.

Verification
REQ-029 Default parameters, in0 toggling 0 / 8000 (=2000 mV is not above threshold; use 12000) every 100 strobes -> out0 fires every edge; out1 fires on edges 1,3,5; out2 on edges 1,4,7; out3 on edges 1,5,9; each pulse is 48 strobes at 20000.
REQ-030 in0 oscillating between 3000 and 7000 after one rise -> no further edges; outputs return to 0 after 48 strobes.
REQ-031 Clock edges every 20 strobes with TRIG_SAMPLES=48 -> out0 stays high continuously, and each edge reloads the width to 48.
REQ-032 After 2 clock edges, a reset edge followed by a clock edge -> all four channels fire; the next edge fires only out0.
REQ-033 Reset edge and clock edge in the same strobe -> all four fire; subsequent edges continue the out1 pattern fire/skip.
REQ-034 rst_n pulled low mid-trigger, between clk edges -> outputs 0 without waiting for clk; the first edge after release fires all channels.
